// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : APB requester. Accepts one command at a time on a simple
//                valid/ready command port and turns it into an APB
//                SETUP/ACCESS transfer toward one of NUM_SLV peripherals.
//                The slave index is taken from cmd_addr[23:20]; PRDATA and
//                PREADY of the selected slave are muxed back. ACCESS wait
//                states are bounded by a timeout, and every command yields
//                exactly one single-cycle response pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_SLV     number of APB slaves (1..16, index is a 4-bit field)
//    TIMEOUT     max ACCESS cycles with PREADY low before abort (1..255)
//  Ports
//    PCLK        in   1              APB clock
//    PRESETn     in   1              asynchronous active-low reset
//    cmd_valid   in   1              command request
//    cmd_ready   out  1              high while IDLE; accept = valid & ready
//    cmd_write   in   1              1 = write, 0 = read
//    cmd_addr    in   24             [23:20] slave, [19:2] word addr
//    cmd_wdata   in   32             write data
//    rsp_valid   out  1              one-cycle response pulse
//    rsp_rdata   out  32             read data / 0 on write / DEADBEEF on error
//    rsp_err     out  1              timeout or unmapped slave
//    PSEL        out  NUM_SLV        one-hot slave select
//    PADDR       out  18             word address
//    PENABLE     out  1              access phase
//    PWRITE      out  1              write control
//    PWDATA      out  32             write data
//    PRDATA_BUS  in   32*NUM_SLV     slave k read data at [32k+31:32k]
//    PREADY_BUS  in   NUM_SLV        slave k ready at bit k
// ============================================================================
module apb_master_bridge #(
    parameter int NUM_SLV = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [23:0]             cmd_addr,
    input  logic [31:0]             cmd_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic [17:0]             PADDR,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    input  logic [32*NUM_SLV-1:0]   PRDATA_BUS,
    input  logic [NUM_SLV-1:0]      PREADY_BUS
);

    localparam logic [31:0] c_ERR_DATA     = 32'hDEAD_BEEF;
    // Abort fires on the ACCESS cycle whose increment would reach TIMEOUT.
    localparam logic [7:0]  c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [NUM_SLV-1:0]     r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [17:0]            r_paddr;
    logic [31:0]            r_pwdata;
    logic [7:0]             r_tcnt;
    logic                   r_rsp_valid;
    logic [31:0]            r_rsp_rdata;
    logic                   r_rsp_err;

    // ------------------------------------------------------------------------
    // Next-state / next-output wires
    // ------------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [NUM_SLV-1:0]     w_psel_nxt;
    logic                   w_penable_nxt;
    logic                   w_pwrite_nxt;
    logic [17:0]            w_paddr_nxt;
    logic [31:0]            w_pwdata_nxt;
    logic [7:0]             w_tcnt_nxt;
    logic                   w_rsp_valid_nxt;
    logic [31:0]            w_rsp_rdata_nxt;
    logic                   w_rsp_err_nxt;

    logic [3:0]             w_cmd_idx;
    logic                   w_cmd_mapped;
    logic [NUM_SLV-1:0]     w_cmd_sel;
    logic                   w_pready;
    logic [31:0]            w_prdata;
    logic                   w_unused_addr_lsb;

    assign w_cmd_idx         = cmd_addr[23:20];
    assign w_cmd_mapped      = (32'(w_cmd_idx) < 32'(NUM_SLV));
    // Byte-lane bits of the command address carry no meaning on APB.
    assign w_unused_addr_lsb = ^cmd_addr[1:0];

    // One-hot decode of the incoming command's slave index.
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_dec
        assign w_cmd_sel[k] = (32'(w_cmd_idx) == k);
    end

    // PSEL is held one-hot for the whole transfer, so it doubles as the
    // read-back mux select; unselected slaves contribute nothing.
    always_comb begin
        w_pready = 1'b0;
        w_prdata = 32'd0;
        for (int k = 0; k < NUM_SLV; k++) begin
            w_pready = w_pready | (r_psel[k] & PREADY_BUS[k]);
            w_prdata = w_prdata | ({32{r_psel[k]}} & PRDATA_BUS[32*k +: 32]);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 18'd0;
            r_pwdata    <= 32'd0;
            r_tcnt      <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and registered-output values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_tcnt_nxt      = r_tcnt;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_cmd_mapped) begin
                        w_state_nxt   = S_SETUP;
                        w_psel_nxt    = w_cmd_sel;
                        w_penable_nxt = 1'b0;
                        w_pwrite_nxt  = cmd_write;
                        w_paddr_nxt   = cmd_addr[19:2];
                        w_pwdata_nxt  = cmd_wdata;
                        w_tcnt_nxt    = 8'd0;
                    end else begin
                        // Unmapped slave: answer immediately, bus untouched.
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = c_ERR_DATA;
                    end
                end
            end

            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
            end

            S_ACCESS: begin
                if (w_pready) begin
                    w_state_nxt     = S_IDLE;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_pwrite ? 32'd0 : w_prdata;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                    if (r_tcnt >= c_TIMEOUT_LAST) begin
                        w_state_nxt     = S_IDLE;
                        w_psel_nxt      = '0;
                        w_penable_nxt   = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = c_ERR_DATA;
                    end
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PADDR     = r_paddr;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Self-checking bench for apb_master_bridge (4 slaves,
//                timeout 4). Expected responses and APB transfers are queued
//                when a command is issued; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int NS = 4;
    localparam int TO = 4;

    // Slave k inserts SLV_WAIT[k] wait states; slave 1 never becomes ready.
    localparam int          SLV_WAIT  [NS] = '{3, 255, 0, 0};
    localparam logic [31:0] SLV_RDATA [NS] = '{32'hCAFE_F00D, 32'h1111_2222,
                                               32'h2222_3333, 32'h3333_4444};

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [23:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [NS-1:0]     PSEL;
    logic [17:0]       PADDR;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [32*NS-1:0]  prdata_bus;
    logic [NS-1:0]     pready_bus = '1;

    apb_master_bridge #(.NUM_SLV(NS), .TIMEOUT(TO)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .PSEL       (PSEL),
        .PADDR      (PADDR),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA_BUS (prdata_bus),
        .PREADY_BUS (pready_bus)
    );

    always #5 PCLK = ~PCLK;

    for (genvar k = 0; k < NS; k++) begin : g_rdata
        assign prdata_bus[32*k +: 32] = SLV_RDATA[k];
    end

    int cyc = 0;
    always @(posedge PCLK) cyc++;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [NS-1:0] psel;
        logic [17:0]   paddr;
        logic          pwrite;
        logic [31:0]   pwdata;
        int            setup_cyc;
        int            acc_len;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];

    // ------------------------------------------------------------------------
    // Slave model: selected slave raises PREADY after its wait count;
    // unselected slaves always show PREADY=1 so a wrong mux is exposed.
    // ------------------------------------------------------------------------
    int acc_cnt = 0;
    always @(negedge PCLK) begin
        for (int k = 0; k < NS; k++)
            pready_bus[k] = (PSEL[k] && PENABLE) ? (acc_cnt >= SLV_WAIT[k]) : 1'b1;
        acc_cnt = PENABLE ? acc_cnt + 1 : 0;
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    rsp_t m_rsp;
    apb_t m_cur;
    bit   m_have = 1'b0;
    int   m_acc  = 0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            m_have = 1'b0;
            m_acc  = 0;
        end else begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_evt("rsp_unexpected");
                else begin
                    m_rsp = rsp_q.pop_front();
                    check("rsp_err",     64'(rsp_err),   64'(m_rsp.err));
                    check("rsp_rdata",   64'(rsp_rdata), 64'(m_rsp.rdata));
                    check("rsp_latency", 64'(cyc - m_rsp.acc_cyc), 64'(m_rsp.lat));
                end
            end
            if (PENABLE) begin
                if (!m_have) fail_evt("apb_access_unexpected");
                else begin
                    check("apb_access_stable", 64'({PSEL, PADDR, PWRITE, PWDATA}),
                          64'({m_cur.psel, m_cur.paddr, m_cur.pwrite, m_cur.pwdata}));
                    m_acc++;
                end
            end else begin
                if (m_acc > 0) begin
                    check("apb_access_len", 64'(m_acc), 64'(m_cur.acc_len));
                    m_acc  = 0;
                    m_have = 1'b0;
                end
                if (PSEL != '0) begin
                    if (apb_q.size() == 0) fail_evt("apb_setup_unexpected");
                    else begin
                        m_cur  = apb_q.pop_front();
                        m_have = 1'b1;
                        check("apb_setup", 64'({PSEL, PADDR, PWRITE, PWDATA}),
                              64'({m_cur.psel, m_cur.paddr, m_cur.pwrite, m_cur.pwdata}));
                        check("apb_setup_cycle", 64'(cyc), 64'(m_cur.setup_cyc));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int last_acc = 0;
    int gap      = 0;

    // Drives a command from the next falling edge and returns at the falling
    // edge just before the accepting rising edge (cmd_valid stays high).
    task automatic send(input logic wr, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [NS-1:0] e_psel, input logic [17:0] e_paddr,
                        input logic e_err, input logic [31:0] e_rd,
                        input int e_lat, input int e_acc);
        rsp_t r;
        apb_t a;
        int   n;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) fail_evt("cmd_ready_timeout");
        else begin
            r.err = e_err; r.rdata = e_rd; r.acc_cyc = cyc; r.lat = e_lat;
            rsp_q.push_back(r);
            if (e_psel != '0) begin
                a.psel = e_psel; a.paddr = e_paddr; a.pwrite = wr; a.pwdata = wd;
                a.setup_cyc = cyc + 1; a.acc_len = e_acc;
                apb_q.push_back(a);
            end
            gap      = cyc - last_acc;
            last_acc = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 24'hFF_FFFF;
        cmd_wdata = 32'hA5A5_A5A5;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_apb"},    64'({PSEL, PENABLE, PWRITE, PADDR}), 64'(0));
        check({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
        check({tag, "_rsp"},    64'({rsp_valid, rsp_err}), 64'(0));
        check({tag, "_rdata"},  64'(rsp_rdata), 64'(0));
        check({tag, "_ready"},  64'(cmd_ready), 64'(1));
    endtask

    initial begin
        int n;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 24'd0;
        cmd_wdata = 32'd0;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESETn = 1'b1;
        idle(1);

        // Zero-wait write to slave 2.
        send(1'b1, 24'h20_0004, 32'h1234_5678, 4'b0100, 18'h1, 1'b0, 32'h0, 3, 1);
        idle(4);

        // Read slave 0 with 3 wait states.
        send(1'b0, 24'h00_0000, 32'h0BAD_0BAD, 4'b0001, 18'h0, 1'b0, 32'hCAFE_F00D, 6, 4);
        idle(7);

        // Read slave 3 at the top word address; low address bits ignored.
        send(1'b0, 24'h3F_FFFF, 32'h0, 4'b1000, 18'h3FFFF, 1'b0, 32'h3333_4444, 3, 1);
        idle(4);

        // Stuck slave: abort after TIMEOUT wait cycles.
        send(1'b0, 24'h10_0040, 32'h0, 4'b0010, 18'h10, 1'b1, 32'hDEAD_BEEF, 6, 4);
        idle(7);

        // Unmapped slaves 5, 4 (first out of range), 15: back-to-back.
        send(1'b1, 24'h50_0010, 32'h55, 4'b0000, 18'h0, 1'b1, 32'hDEAD_BEEF, 1, 0);
        send(1'b0, 24'h40_0000, 32'h0,  4'b0000, 18'h0, 1'b1, 32'hDEAD_BEEF, 1, 0);
        check("unmapped_gap", 64'(gap), 64'(1));
        send(1'b0, 24'hF0_0000, 32'h0,  4'b0000, 18'h0, 1'b1, 32'hDEAD_BEEF, 1, 0);
        check("unmapped_gap", 64'(gap), 64'(1));
        idle(3);

        // Three writes with cmd_valid held high: 3-cycle throughput.
        send(1'b1, 24'h20_0100, 32'h1111_0001, 4'b0100, 18'h40,    1'b0, 32'h0, 3, 1);
        send(1'b1, 24'h3A_BCDC, 32'h2222_0002, 4'b1000, 18'h2AF37, 1'b0, 32'h0, 3, 1);
        check("b2b_gap", 64'(gap), 64'(3));
        send(1'b1, 24'h2F_FFF0, 32'h3333_0003, 4'b0100, 18'h3FFFC, 1'b0, 32'h0, 3, 1);
        check("b2b_gap", 64'(gap), 64'(3));
        idle(4);

        // Reset during ACCESS of a stuck read, then a normal write.
        send(1'b0, 24'h10_0000, 32'h0, 4'b0010, 18'h0, 1'b1, 32'hDEAD_BEEF, 6, 4);
        @(posedge PCLK);
        @(posedge PCLK);
        #2;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        rsp_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        idle(2);
        send(1'b1, 24'h30_0008, 32'hFEED_FACE, 4'b1000, 18'h2, 1'b0, 32'h0, 3, 1);
        idle(2);

        n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        check("apb_queue_drained", 64'(apb_q.size()), 64'(0));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
